layer_serializer: RTL and testbench
===================================

# layer_serializer

Parallel-to-serial adapter between two fully connected layers. It captures the DIM-wide activation vector that a layer presents with a one-cycle valid, converts each element from the narrow activation format to the wider layer-input format, and streams the elements one per cycle, index 0 first. The output stream is the `in_dat`/`in_valid` stream that the next layer's neurons consume.

## Interface
Parameters:
- `DIM` — default 8 — number of vector elements (upstream layer DIM_OUTPUT).
- `IN_W` — default 8 — element width in, signed [1,7].
- `IN_FRAC` — default 7 — fractional bits of input element.
- `OUT_W` — default 16 — stream width out, signed [9,7].
- `OUT_FRAC` — default 7 — fractional bits of output element.

Ports:
- `clk` — in — 1 — sole clock, rising edge.
- `rst_n` — in — 1 — asynchronous, active-low reset.
- `in_dat` — in — [IN_W-1:0] x [DIM-1:0] — unpacked parallel vector from the upstream layer.
- `in_valid` — in — 1 — single-cycle strobe; `in_dat` is valid this cycle only.
- `out_dat` — out — [OUT_W-1:0] — serial element, converted format.
- `out_valid` — out — 1 — `out_dat` valid this cycle; no backpressure exists.
- `out_last` — out — 1 — high with element DIM-1.
- `busy` — out — 1 — high while streaming or holding a pending vector.
- `overflow` — out — 1 — one-cycle pulse when an incoming vector is dropped.

## Operation
- States: IDLE, STREAM. Index counter `idx` has width $clog2(DIM), with a minimum of 1.
- IDLE + `in_valid`: capture all DIM elements into the active bank, set `idx`=0, go to STREAM.
- STREAM, each cycle: drive `out_dat` = conv(active[idx]) and `out_valid`=1; `out_last`=(idx==DIM-1); then idx++.
- At idx==DIM-1, pick the first matching case:
  - `in_valid` this cycle: capture into active, `idx`=0, stay in STREAM. Element 0 of the new vector follows without a gap.
  - (DBUF) pending bank full: move pending to active, `idx`=0, stay in STREAM.
  - Otherwise: go to IDLE.
- `in_valid` while in STREAM with idx<DIM-1: see Configuration.
- Conversion: conv(x) = sign_extend(x, OUT_W) << (OUT_FRAC-IN_FRAC). The conversion is exact, with no rounding or saturation.
- Elaboration-time `$error` if OUT_FRAC<IN_FRAC or (OUT_W-OUT_FRAC)<(IN_W-IN_FRAC).
- Element order is fixed at index 0 first, matching the next layer's weight memory order.

## Timing
- Reset (async assert, sync release) sets: state=IDLE, idx=0, banks=0, pending flag=0, `out_dat`=0, `out_valid`=0, `out_last`=0, `busy`=0, `overflow`=0.
- All outputs are registered.
- Latency: `in_valid` at edge t produces element 0 at cycle t+1 and element k at t+1+k. `out_last` is at t+DIM.
- Burst: exactly DIM consecutive `out_valid` cycles per accepted vector. Back-to-back vectors run with no idle cycle between them.
- `busy` is high from t+1 until the cycle after the last element of the final queued vector.
- Reset mid-stream aborts the burst immediately and loses any partial vector. The bench must not expect a completed burst.
- DIM=1: every accepted vector yields one cycle with `out_valid`=`out_last`=1.

## Configuration
- `LAYER_SER_DBUF_EN` defined:
  - Adds a pending bank plus flag.
  - `in_valid` during STREAM (idx<DIM-1) with pending empty: capture into pending.
  - Pending already full: drop the new vector, pulse `overflow`, keep the old pending vector.
- Not defined:
  - No pending bank.
  - `in_valid` during STREAM with idx<DIM-1: drop the vector and pulse `overflow`. The active burst is unaffected.

## Structure
- Shared package `fc_pkg` holds:
  - Fixed-point width/frac constants: ACT_W=8, ACT_FRAC=7, LIN_W=16, LIN_FRAC=7.
  - Layer DIM constants.
  - `ser_state_t` enum {IDLE, STREAM}.
- Sub-module `fxp_widen` (combinational; IN_W/IN_FRAC/OUT_W/OUT_FRAC) performs sign-extend and shift. It is instantiated once on the muxed element, not per element.

## Test plan
- DIM=8, single vector {8'h7F,8'h80,8'h01,8'hFF,0,0,0,8'h40} -> 8 cycles starting t+1: 16'h007F,16'hFF80,16'h0001,16'hFFFF,0,0,0,16'h0040. `out_last` only on the 8th cycle; `busy` drops after it.
- New `in_valid` coincident with `out_last` cycle -> 16 contiguous `out_valid` cycles, second vector starting immediately, `overflow`=0.
- `in_valid` at idx=3, macro off -> first burst completes unchanged, `overflow` pulses 1 cycle, then IDLE.
- Same stimulus, macro on -> second vector streams immediately after the first `out_last`. A third `in_valid` during the first burst -> `overflow` pulse, and the third vector never appears.
- `rst_n` low at idx=5 -> all outputs 0 asynchronously. After release, the next `in_valid` streams from element 0.
- IN_FRAC=6, OUT_FRAC=7, element 8'hC0 -> 16'hFF80.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared fixed-point formats, layer sizes and serializer state type for the FC pipeline.
package fc_pkg;
    localparam int ACT_W    = 8;
    localparam int ACT_FRAC = 7;
    localparam int LIN_W    = 16;
    localparam int LIN_FRAC = 7;
    localparam int L1_DIM   = 8;
    localparam int L2_DIM   = 8;
    typedef enum logic {IDLE, STREAM} ser_state_t;
endpackage

// File: rtl/fxp_widen.sv
// fxp_widen: exact signed fixed-point widening (sign-extend, then align the binary point).
module fxp_widen
    import fc_pkg::*;
#(
    parameter int IN_W     = ACT_W,
    parameter int IN_FRAC  = ACT_FRAC,
    parameter int OUT_W    = LIN_W,
    parameter int OUT_FRAC = LIN_FRAC
) (
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y
);
    if (OUT_FRAC < IN_FRAC || (OUT_W - OUT_FRAC) < (IN_W - IN_FRAC)) begin : g_bad_fmt
        $error("fxp_widen: output format cannot represent the input format exactly");
    end
    assign y = OUT_W'($signed(x)) << (OUT_FRAC - IN_FRAC);
endmodule

// File: rtl/layer_serializer.sv
// layer_serializer: captures a DIM-wide activation vector and streams it widened, element 0 first.
// Define LAYER_SER_DBUF_EN to add a pending bank that queues one vector arriving mid-burst.
module layer_serializer
    import fc_pkg::*;
#(
    parameter int DIM      = L1_DIM,
    parameter int IN_W     = ACT_W,
    parameter int IN_FRAC  = ACT_FRAC,
    parameter int OUT_W    = LIN_W,
    parameter int OUT_FRAC = LIN_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_dat [DIM],
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_dat,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             overflow
);
    localparam int IW = DIM > 1 ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    ser_state_t      state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [IN_W-1:0] active [DIM];
    logic [IN_W-1:0] sel;
    logic [OUT_W-1:0] elem;
    logic            load_in, ovf_nx;
`ifdef LAYER_SER_DBUF_EN
    logic [IN_W-1:0] pend [DIM];
    logic            pend_full, load_pend, cap_pend;
`endif

    if (DIM == 1) begin : g_one
        assign sel = active[0];
    end else begin : g_many
        assign sel = active[idx];
    end

    fxp_widen #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC))
        u_widen (.x(sel), .y(elem));

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        load_in  = 1'b0;
        ovf_nx   = 1'b0;
`ifdef LAYER_SER_DBUF_EN
        load_pend = 1'b0;
        cap_pend  = 1'b0;
`endif
        if (state == IDLE) begin
            if (in_valid) begin
                state_nx = STREAM;
                idx_nx   = '0;
                load_in  = 1'b1;
            end
        end else if (idx == LAST) begin
            idx_nx = '0;
            if (in_valid) load_in = 1'b1;
`ifdef LAYER_SER_DBUF_EN
            else if (pend_full) load_pend = 1'b1;
`endif
            else state_nx = IDLE;
        end else begin
            idx_nx = idx + 1'b1;
`ifdef LAYER_SER_DBUF_EN
            cap_pend = in_valid && !pend_full;
            ovf_nx   = in_valid && pend_full;
`else
            ovf_nx = in_valid;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_dat   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_dat   <= state == STREAM ? elem : '0;
            out_valid <= state == STREAM;
            out_last  <= state == STREAM && idx == LAST;
            busy      <= state == STREAM;
            overflow  <= ovf_nx;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) active <= '{default: '0};
        else if (load_in) active <= in_dat;
`ifdef LAYER_SER_DBUF_EN
        else if (load_pend) active <= pend;
`endif

`ifdef LAYER_SER_DBUF_EN
    // a new vector at the last element wins over the pending one, which stays queued
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend      <= '{default: '0};
            pend_full <= 1'b0;
        end else if (cap_pend) begin
            pend      <= in_dat;
            pend_full <= 1'b1;
        end else if (load_pend) begin
            pend_full <= 1'b0;
        end
`endif
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: directed and random stimulus checked against a queue-based stream model.
module tb_layer_serializer;
    localparam int DIM = 8;
`ifdef LAYER_SER_DBUF_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    typedef struct packed {logic [15:0] d; logic l;} elem_t;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_valid2 = 1'b0;
    logic [7:0]  in_dat [DIM];
    logic [7:0]  in_dat2 [1];
    logic [15:0] out_dat, out_dat2;
    logic        out_valid, out_last, busy, overflow;
    logic        out_valid2, out_last2, busy2, overflow2;

    logic [7:0]  nv [DIM];
    logic [7:0]  nv2;
    elem_t       q[$];
    bit          pend_h;
    logic [7:0]  pend_v [DIM];
    logic [15:0] ex_dat, e2_dat, p2_dat;
    bit          ex_valid, ex_last, ex_ovf, e2_valid, p2_valid;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    layer_serializer u_dut (
        .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_valid(in_valid),
        .out_dat(out_dat), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    layer_serializer #(.DIM(1), .IN_FRAC(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_dat(in_dat2), .in_valid(in_valid2),
        .out_dat(out_dat2), .out_valid(out_valid2), .out_last(out_last2),
        .busy(busy2), .overflow(overflow2)
    );

    function automatic logic [15:0] conv(input logic [7:0] x, input int sh);
        int v;
        v = $signed(x);
        v = v * (1 << sh);
        return v[15:0];
    endfunction

    task automatic push_vec(input logic [7:0] v [DIM]);
        for (int k = 0; k < DIM; k++) q.push_back('{d: conv(v[k], 0), l: k == DIM - 1});
    endtask

    task automatic model_edge(input bit v, input bit v2);
        elem_t e;
        ex_valid = q.size() > 0;
        ex_dat = 16'h0;
        ex_last = 1'b0;
        ex_ovf = 1'b0;
        if (ex_valid) begin
            e = q.pop_front();
            ex_dat = e.d;
            ex_last = e.l;
        end
        if (q.size() == 0) begin
            if (v) push_vec(nv);
            else if (pend_h) begin
                push_vec(pend_v);
                pend_h = 1'b0;
            end
        end else if (v) begin
            if (DB && !pend_h) begin
                pend_h = 1'b1;
                pend_v = nv;
            end else ex_ovf = 1'b1;
        end
        e2_valid = p2_valid;
        e2_dat = p2_dat;
        p2_valid = v2;
        p2_dat = v2 ? conv(nv2, 1) : 16'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_dat", 32'(out_dat), 32'(ex_dat));
        chk("out_valid", 32'(out_valid), 32'(ex_valid));
        chk("out_last", 32'(out_last), 32'(ex_last));
        chk("busy", 32'(busy), 32'(ex_valid));
        chk("overflow", 32'(overflow), 32'(ex_ovf));
        chk("dim1_out_dat", 32'(out_dat2), 32'(e2_dat));
        chk("dim1_out_valid", 32'(out_valid2), 32'(e2_valid));
        chk("dim1_out_last", 32'(out_last2), 32'(e2_valid));
        chk("dim1_busy", 32'(busy2), 32'(e2_valid));
        chk("dim1_overflow", 32'(overflow2), 32'd0);
    endtask

    task automatic step(input bit v, input bit v2);
        @(negedge clk);
        in_valid = v;
        in_dat = nv;
        in_valid2 = v2;
        in_dat2[0] = nv2;
        @(posedge clk);
        model_edge(v, v2);
        #1;
        check_all();
    endtask

    task automatic rand_vec();
        for (int k = 0; k < DIM; k++) nv[k] = 8'($urandom);
    endtask

    task automatic clear_model();
        q.delete();
        pend_h = 1'b0;
        p2_valid = 1'b0;
        p2_dat = 16'h0;
        ex_dat = 16'h0;
        ex_valid = 1'b0;
        ex_last = 1'b0;
        ex_ovf = 1'b0;
        e2_valid = 1'b0;
        e2_dat = 16'h0;
    endtask

    initial begin
        nv = '{default: '0};
        nv2 = 8'h0;
        in_dat = nv;
        in_dat2[0] = 8'h0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 1'b0);
        // known vector plus the IN_FRAC=6 conversion case on the DIM=1 instance
        nv = '{8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h40};
        nv2 = 8'hC0;
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        rand_vec();
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        rand_vec();
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        rand_vec();
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        rand_vec();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        rand_vec();
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        repeat (300) begin
            rand_vec();
            nv2 = 8'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (20) step(1'b0, 1'b0);
        rand_vec();
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        check_all();
        @(negedge clk) rst_n = 1'b1;
        rand_vec();
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
